// File: rtl/decrypt_out_fifo_if.sv
// Handshake bundle between the decryption mux, the output FIFO and the
// character consumer.
//   data_i/valid_i  : decrypted character from the mux (no backpressure)
//   data_o/valid_o  : head-of-FIFO character, ready_i is the consumer accept
//   count_o, full_o, empty_o, overflow_o, eom_o : FIFO status
// The slave modport is the FIFO side; master is the producer/consumer side.
interface decrypt_out_fifo_if #(
    parameter int D_WIDTH = 8,
    parameter int DEPTH   = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [D_WIDTH-1:0] data_i;
    logic               valid_i;
    logic [D_WIDTH-1:0] data_o;
    logic               valid_o;
    logic               ready_i;
    logic [CW-1:0]      count_o;
    logic               full_o;
    logic               empty_o;
    logic               overflow_o;
    logic               eom_o;

    modport slave (
        input  data_i, valid_i, ready_i,
        output data_o, valid_o, count_o, full_o, empty_o, overflow_o, eom_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  data_o, valid_o, count_o, full_o, empty_o, overflow_o, eom_o
    );
endinterface

// File: rtl/decrypt_out_fifo.sv
// Output buffer behind the decryption-engine select mux. Every valid
// decrypted character is stored in a circular FIFO and offered to the
// consumer first-word-fall-through over ready/valid.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous reset, active HIGH despite the name
//   bus    : decrypt_out_fifo_if.slave (data/valid in, data/valid/ready out,
//            count/full/empty, sticky overflow, end-of-message pulse)
module decrypt_out_fifo #(
    parameter int                 D_WIDTH   = 8,
    parameter int                 DEPTH     = 8,
    parameter logic [D_WIDTH-1:0] TERM_CHAR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decrypt_out_fifo_if.slave     bus
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               overflow_q, overflow_d;
    logic               eom_q, eom_d;
    logic               push, pop, drop;
    logic [D_WIDTH-1:0] head;

    // Head reads as zero while empty so data_o never shows stale memory.
    assign head = empty_q ? '0 : mem_q[rd_ptr_q];

    assign pop  = !empty_q && bus.ready_i;
    // A full FIFO still accepts a character when the head leaves the same cycle.
    assign push = bus.valid_i && (!full_q || pop);
    assign drop = bus.valid_i && full_q && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        eom_d      = pop && (head == TERM_CHAR);

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            eom_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            eom_q      <= eom_d;
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.data_i;
    end

    assign bus.data_o     = head;
    assign bus.valid_o    = !empty_q;
    assign bus.count_o    = count_q;
    assign bus.full_o     = full_q;
    assign bus.empty_o    = empty_q;
    assign bus.overflow_o = overflow_q;
    assign bus.eom_o      = eom_q;
endmodule

// File: tb/tb_decrypt_out_fifo.sv
module tb_decrypt_out_fifo;
    localparam int         DW    = 8;
    localparam int         DEPTH = 8;
    localparam logic [7:0] TERM  = 8'h00;

    logic clk;
    logic rst_n;

    decrypt_out_fifo_if #(.D_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    decrypt_out_fifo #(.D_WIDTH(DW), .DEPTH(DEPTH), .TERM_CHAR(TERM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;

    logic [7:0] sb[$];
    logic       m_ovf;
    logic       m_eom;

    // Drives one cycle of stimulus, samples the head before the edge and
    // advances the reference model across the edge. No checking here.
    task automatic tick(input logic v, input logic [7:0] d, input logic r,
                        output logic popped, output logic [7:0] act,
                        output logic [7:0] exp);
        logic do_push;
        bus.valid_i = v;
        bus.data_i  = d;
        bus.ready_i = r;
        #1;
        act     = bus.data_o;
        popped  = (sb.size() != 0) && r;
        do_push = v && ((sb.size() < DEPTH) || popped);
        exp     = 8'h00;
        if (popped) exp = sb.pop_front();
        m_eom = popped && (exp == TERM);
        if (do_push) sb.push_back(d);
        else if (v) m_ovf = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        bus.ready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        m_eom = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        bus.ready_i = 1'b0;
        rst_n = 1'b1;
        #12;
        n_cmp++; if (bus.count_o !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", bus.count_o); end
        n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b want=1", bus.empty_o); end
        n_cmp++; if (bus.full_o !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b want=0", bus.full_o); end
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
        n_cmp++; if (bus.data_o !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h want=00", bus.data_o); end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", bus.overflow_o); end
        n_cmp++; if (bus.eom_o !== 1'b0) begin n_err++; $display("FAIL reset_eom got=%b want=0", bus.eom_o); end
        do_reset();
    endtask

    task automatic test_hold();
        logic p; logic [7:0] a, e;
        do_reset();
        tick(1'b1, 8'h41, 1'b0, p, a, e);
        n_cmp++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h41) begin n_err++; $display("FAIL latency1 got=%b/%h want=1/41", bus.valid_o, bus.data_o); end
        tick(1'b1, 8'h42, 1'b0, p, a, e);
        tick(1'b1, 8'h43, 1'b0, p, a, e);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.count_o !== 4'd3) begin n_err++; $display("FAIL hold_count got=%0d want=3", bus.count_o); end
            n_cmp++; if (bus.data_o !== 8'h41 || bus.valid_o !== 1'b1) begin n_err++; $display("FAIL hold_head got=%b/%h want=1/41", bus.valid_o, bus.data_o); end
            tick(1'b0, 8'h00, 1'b0, p, a, e);
        end
    endtask

    task automatic test_overflow();
        logic p; logic [7:0] a, e;
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b1, 8'(i), 1'b0, p, a, e);
        n_cmp++; if (bus.full_o !== 1'b1) begin n_err++; $display("FAIL ovf_full got=%b want=1", bus.full_o); end
        n_cmp++; if (bus.count_o !== 4'd8) begin n_err++; $display("FAIL ovf_count got=%0d want=8", bus.count_o); end
        n_cmp++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b want=1", bus.overflow_o); end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 8'h00, 1'b1, p, a, e);
            n_cmp++; if (a !== 8'(i) || p !== 1'b1) begin n_err++; $display("FAIL drain_order got=%h want=%h", a, 8'(i)); end
        end
        n_cmp++; if (bus.empty_o !== 1'b1 || bus.count_o !== 4'd0) begin n_err++; $display("FAIL drain_empty got=%b/%0d want=1/0", bus.empty_o, bus.count_o); end
        n_cmp++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b want=1", bus.overflow_o); end
    endtask

    task automatic test_full_passthrough();
        logic p; logic [7:0] a, e;
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 8'h10 + 8'(i), 1'b0, p, a, e);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 8'h20 + 8'(i), 1'b1, p, a, e);
            n_cmp++; if (a !== e) begin n_err++; $display("FAIL pass_order got=%h want=%h", a, e); end
            n_cmp++; if (bus.count_o !== 4'd8 || bus.full_o !== 1'b1) begin n_err++; $display("FAIL pass_count got=%0d want=8", bus.count_o); end
            n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL pass_ovf got=%b want=0", bus.overflow_o); end
        end
    endtask

    task automatic test_eom();
        logic p; logic [7:0] a, e;
        do_reset();
        tick(1'b1, 8'h48, 1'b0, p, a, e);
        tick(1'b1, 8'h00, 1'b0, p, a, e);
        tick(1'b0, 8'h00, 1'b1, p, a, e);
        n_cmp++; if (a !== 8'h48 || bus.eom_o !== 1'b0) begin n_err++; $display("FAIL eom_first got=%h/%b want=48/0", a, bus.eom_o); end
        tick(1'b0, 8'h00, 1'b1, p, a, e);
        n_cmp++; if (bus.eom_o !== 1'b1 || p !== 1'b1) begin n_err++; $display("FAIL eom_pulse got=%b want=1", bus.eom_o); end
        tick(1'b0, 8'h00, 1'b1, p, a, e);
        n_cmp++; if (bus.eom_o !== 1'b0) begin n_err++; $display("FAIL eom_width got=%b want=0", bus.eom_o); end
    endtask

    task automatic test_mid_reset();
        logic p; logic [7:0] a, e;
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 8'h60 + 8'(i), 1'b0, p, a, e);
        n_cmp++; if (bus.count_o !== 4'd5) begin n_err++; $display("FAIL mid_pre_count got=%0d want=5", bus.count_o); end
        bus.valid_i = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL mid_valid got=%b want=0", bus.valid_o); end
        n_cmp++; if (bus.count_o !== 4'd0) begin n_err++; $display("FAIL mid_count got=%0d want=0", bus.count_o); end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL mid_ovf got=%b want=0", bus.overflow_o); end
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        m_eom = 1'b0;
        @(posedge clk);
        #1;
        tick(1'b1, 8'h5A, 1'b0, p, a, e);
        n_cmp++; if (bus.data_o !== 8'h5A || bus.valid_o !== 1'b1 || bus.count_o !== 4'd1) begin n_err++; $display("FAIL mid_head got=%h/%b/%0d want=5a/1/1", bus.data_o, bus.valid_o, bus.count_o); end
    endtask

    task automatic test_random();
        logic p; logic [7:0] a, e, d;
        logic v, r;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            v = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 30 : 70));
            d = ($urandom_range(0, 7) == 0) ? TERM : 8'($urandom_range(1, 255));
            tick(v, d, r, p, a, e);
            if (p) begin
                n_cmp++; if (a !== e) begin n_err++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, a, e); end
            end
            n_cmp++; if (bus.count_o !== 4'(sb.size())) begin n_err++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", i, bus.count_o, sb.size()); end
            n_cmp++; if (bus.full_o !== (sb.size() == DEPTH) || bus.empty_o !== (sb.size() == 0) || bus.valid_o !== (sb.size() != 0)) begin n_err++; $display("FAIL rnd_flags cyc=%0d got=f%b e%b v%b size=%0d", i, bus.full_o, bus.empty_o, bus.valid_o, sb.size()); end
            n_cmp++; if (bus.overflow_o !== m_ovf || bus.eom_o !== m_eom) begin n_err++; $display("FAIL rnd_ovf_eom cyc=%0d got=%b/%b want=%b/%b", i, bus.overflow_o, bus.eom_o, m_ovf, m_eom); end
            if (sb.size() != 0) begin
                n_cmp++; if (bus.data_o !== sb[0]) begin n_err++; $display("FAIL rnd_head cyc=%0d got=%h want=%h", i, bus.data_o, sb[0]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        m_ovf = 1'b0;
        m_eom = 1'b0;
        test_reset();
        test_hold();
        test_overflow();
        test_full_passthrough();
        test_eom();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
